iob_clint: RTL and testbench
============================

Name: iob_clint

Overview:
- RISC-V Core-Local Interruptor (CLINT) on the IOb native memory bus.
- Holds a 64-bit real-time counter (mtime), one 64-bit compare register (mtimecmp) per hart, and one software-interrupt bit (msip) per hart.
- Drives per-hart machine timer (mtip) and machine software (msip) interrupt lines into the CPU cores of the SoC.
- mtime advances on rising edges of a slow real-time clock, sampled into the system clock domain.

Parameters:
- ADDR_W, 16, bus byte-address width.
- DATA_W, 32, bus data width (fixed at 32).
- N_CORES, 1, number of harts (1..16).

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rt_clk  in  1  real-time clock, asynchronous to clk and slower than clk/4.
- valid  in  1  request strobe, one clk cycle per request.
- address  in  ADDR_W  byte address; bits [1:0] ignored.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write enables; all zero means read.
- rdata  out  DATA_W  read data.
- ready  out  1  response strobe.
- mtip  out  N_CORES  machine timer interrupt, one bit per hart.
- msip  out  N_CORES  machine software interrupt, one bit per hart.

Behaviour:
- Memory map (byte addresses), each entry one 32-bit word:
  - msip[h] at 0x0000 + 4h; only bit 0 is implemented, other bits read as 0.
  - mtimecmp[h] low word at 0x4000 + 8h; high word at 0x4004 + 8h.
  - mtime low word at 0xBFF8; high word at 0xBFFC.
- Unmapped addresses: reads return 0, writes are ignored, ready is still returned.
- Handshake:
  - When valid=1 is sampled, ready=1 for exactly one cycle on the next cycle, with rdata valid in that same cycle.
  - Writes take effect on the valid edge and are visible to reads issued from the following request onward.
  - ready=0 when no request is pending.
  - rdata holds its last value when ready=0.
  - A new valid in the same cycle as ready is accepted.
- Writes are byte-granular per wstrb, for all registers.
- rt_clk is passed through a 2-flop synchronizer plus an edge-detect flop in the clk domain; each detected rising edge produces a one-cycle tick.
- On a tick, mtime increments by 1, wrapping modulo 2^64.
- A bus write to mtime in the same cycle as a tick wins: the written bytes are loaded and the tick is dropped. Unwritten bytes keep their value without incrementing.
- Outputs:
  - mtip[h] = (mtime >= mtimecmp[h]), unsigned 64-bit compare, registered (one cycle after the operands change).
  - msip[h] = msip register bit of hart h, registered.
- Reset values:
  - mtime = 0.
  - mtimecmp[h] = 0xFFFF_FFFF_FFFF_FFFF, so no spurious timer interrupt.
  - msip register = 0.
  - mtip = 0, msip = 0, ready = 0, rdata = 0.
  - Synchronizer flops = 0.
- Reset asserted mid-transaction drops the pending response; no ready is issued.
- Software writes the two halves of mtimecmp non-atomically. mtip may glitch between the halves; software handles this, the block does not.

Test Plan:
- Reset: assert rst 100 cycles, release → mtip=0, msip=0, ready=0. Read of 0xBFF8 returns a small count that increases after further rt_clk edges.
- Timer interrupt: write 20 to 0x4000 and 0 to 0x4004 → mtip=0 while mtime<20. mtip rises within 2 clk cycles after mtime reaches 20.
- Software interrupt: write 1 to 0x0000 → msip=1 and read of 0x0000 returns 1. Write 0 → msip=0 next cycle.
- Timer reload: write 0 to 0xBFF8 and 0xBFFC, then 0x4000=100, 0x4004=0 → mtip clears, then reasserts after 100 rt_clk periods.
- Byte strobes and wrap:
  - Write 0xFFFFFFFF to 0xBFF8 and 0xBFFC, then wait one tick → mtime reads 0 and 0.
  - Write wdata=0xAABBCCDD with wstrb=0x2 to 0x4000 → low word reads 0xFFFFCCFF.
- Handshake and decode:
  - Every request yields exactly one ready, one cycle after valid.
  - Read of unmapped address 0x2000 returns 0; a write there changes nothing.
  - Back-to-back requests (valid in the same cycle as ready) each get their own ready.

Source files
------------

// File: rtl/iob_clint.sv
// RISC-V core-local interruptor on the IOb native bus: real-time counter,
// per-hart timer compare and software interrupt bits.
module iob_clint #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_CORES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rt_clk,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic [N_CORES-1:0]    mtip,
  output logic [N_CORES-1:0]    msip
);

  localparam int unsigned N_BYTES = DATA_W / 8;
  localparam int unsigned WORD_W  = ADDR_W - 2;

  // Word addresses of the register map
  localparam logic [WORD_W-1:0] MSIP_BASE  = WORD_W'(16'h0000 >> 2);
  localparam logic [WORD_W-1:0] CMP_BASE   = WORD_W'(16'h4000 >> 2);
  localparam logic [WORD_W-1:0] MTIME_LO_A = WORD_W'(16'hBFF8 >> 2);
  localparam logic [WORD_W-1:0] MTIME_HI_A = WORD_W'(16'hBFFC >> 2);

  logic [WORD_W-1:0]  word_addr;
  logic               wr_en;
  logic               mtime_lo_sel;
  logic               mtime_hi_sel;
  logic [N_CORES-1:0] msip_sel;
  logic [N_CORES-1:0] cmp_lo_sel;
  logic [N_CORES-1:0] cmp_hi_sel;
  logic [DATA_W-1:0]  rd_val;

  logic [1:0]         rt_sync;
  logic               rt_prev;
  logic               tick;

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp [N_CORES];

  logic               unused_addr_lsb;

  assign word_addr       = address[ADDR_W-1:2];
  assign wr_en           = valid & (|wstrb);
  assign tick            = rt_sync[1] & ~rt_prev;
  assign unused_addr_lsb = ^address[1:0];

  // Byte-lane merge of write data into an existing word
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0]  old_val,
    input logic [DATA_W-1:0]  new_val,
    input logic [N_BYTES-1:0] be
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(N_BYTES); i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode
  always_comb begin
    mtime_lo_sel = (word_addr == MTIME_LO_A);
    mtime_hi_sel = (word_addr == MTIME_HI_A);
    msip_sel     = '0;
    cmp_lo_sel   = '0;
    cmp_hi_sel   = '0;
    for (int h = 0; h < int'(N_CORES); h++) begin
      msip_sel[h]   = (word_addr == MSIP_BASE + WORD_W'(h));
      cmp_lo_sel[h] = (word_addr == CMP_BASE + WORD_W'(2*h));
      cmp_hi_sel[h] = (word_addr == CMP_BASE + WORD_W'(2*h + 1));
    end
  end

  // Read data mux; unmapped words read as zero
  always_comb begin
    rd_val = '0;
    if (mtime_lo_sel) rd_val = mtime[31:0];
    if (mtime_hi_sel) rd_val = mtime[63:32];
    for (int h = 0; h < int'(N_CORES); h++) begin
      if (msip_sel[h])   rd_val = DATA_W'(msip[h]);
      if (cmp_lo_sel[h]) rd_val = mtimecmp[h][31:0];
      if (cmp_hi_sel[h]) rd_val = mtimecmp[h][63:32];
    end
  end

  // Real-time clock synchronizer and rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rt_sync <= '0;
      rt_prev <= 1'b0;
    end else begin
      rt_sync <= {rt_sync[0], rt_clk};
      rt_prev <= rt_sync[1];
    end
  end

  // mtime: a bus write in a tick cycle wins and drops the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_en && (mtime_lo_sel || mtime_hi_sel)) begin
      if (mtime_lo_sel) mtime[31:0]  <= merge_bytes(mtime[31:0], wdata, wstrb);
      if (mtime_hi_sel) mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Per-hart compare registers, msip bits and registered timer interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < int'(N_CORES); h++) begin
        mtimecmp[h] <= '1;
      end
      msip <= '0;
      mtip <= '0;
    end else begin
      for (int h = 0; h < int'(N_CORES); h++) begin
        if (wr_en && cmp_lo_sel[h])
          mtimecmp[h][31:0] <= merge_bytes(mtimecmp[h][31:0], wdata, wstrb);
        if (wr_en && cmp_hi_sel[h])
          mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wdata, wstrb);
        if (wr_en && msip_sel[h] && wstrb[0])
          msip[h] <= wdata[0];
        mtip[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

  // Bus response: one ready per request, rdata held between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      if (valid) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_iob_clint.sv
// Directed bench for iob_clint with a response scoreboard.
module tb_iob_clint;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_CORES = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                rt_clk;
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic [N_CORES-1:0]  mtip;
  logic [N_CORES-1:0]  msip;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  iob_clint #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_CORES(N_CORES)) dut (
    .clk(clk), .rst(rst), .rt_clk(rt_clk), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .mtip(mtip), .msip(msip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after a request was sampled
  task automatic collect();
    exp_t e;
    check("ready", 64'(ready), 64'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      if (e.chk) check(e.tag, 64'(rdata), 64'(e.exp));
    end
  endtask

  task automatic push(input logic chk, input logic [31:0] exp, input string tag);
    exp_t e;
    e.chk = chk;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic chk, input logic [31:0] exp, input string tag);
    @(negedge clk);
    valid = 1'b1; address = a; wdata = d; wstrb = be;
    push(chk, exp, tag);
    @(negedge clk);
    valid = 1'b0; wstrb = '0;
    collect();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    bus(a, d, be, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
    bus(a, 32'h0, 4'h0, 1'b1, exp, tag);
  endtask

  // One full real-time clock period: 8 clk cycles
  task automatic rt_tick();
    rt_clk = 1'b1;
    repeat (4) @(negedge clk);
    rt_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rt_clk = 1'b0; valid = 1'b0;
    address = '0; wdata = '0; wstrb = '0;
    repeat (100) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_mtip",  64'(mtip),  64'd0);
    check("rst_msip",  64'(msip),  64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    rd(16'hBFF8, 32'h0, "rst_mtime_lo");
    rd(16'hBFFC, 32'h0, "rst_mtime_hi");
    rd(16'h4000, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(16'h4004, 32'hFFFF_FFFF, "rst_cmp_hi");
    @(negedge clk);
    check("ready_idle0", 64'(ready), 64'd0);

    // mtime counts rt_clk edges
    repeat (3) rt_tick();
    rd(16'hBFF8, 32'd3, "mtime_3");

    // Timer interrupt at 20
    wr(16'h4000, 32'd20, 4'hF);
    wr(16'h4004, 32'd0, 4'hF);
    repeat (2) @(negedge clk);
    check("mtip_below", 64'(mtip), 64'd0);
    repeat (16) rt_tick();
    check("mtip_19", 64'(mtip), 64'd0);
    rd(16'hBFF8, 32'd19, "mtime_19");
    rt_clk = 1'b1;
    repeat (3) @(negedge clk);
    check("mtip_edge_early", 64'(mtip), 64'd0);
    @(negedge clk);
    check("mtip_edge_rise", 64'(mtip), 64'd1);
    rt_clk = 1'b0;
    repeat (4) @(negedge clk);

    // Software interrupt
    wr(16'h0000, 32'd1, 4'hF);
    check("msip_set", 64'(msip), 64'd1);
    rd(16'h0000, 32'd1, "msip_rd1");
    wr(16'h0000, 32'h0, 4'hE);
    check("msip_no_byte0", 64'(msip), 64'd1);
    wr(16'h0000, 32'h0, 4'hF);
    check("msip_clr", 64'(msip), 64'd0);
    wr(16'h0000, 32'hFFFF_FFFF, 4'hF);
    rd(16'h0000, 32'd1, "msip_bit0_only");
    wr(16'h0000, 32'h0, 4'h1);
    rd(16'h0000, 32'd0, "msip_rd0");

    // Timer reload at 100
    wr(16'hBFF8, 32'h0, 4'hF);
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'h4000, 32'd100, 4'hF);
    wr(16'h4004, 32'd0, 4'hF);
    repeat (2) @(negedge clk);
    check("reload_mtip_clr", 64'(mtip), 64'd0);
    repeat (99) rt_tick();
    check("reload_mtip_99", 64'(mtip), 64'd0);
    rd(16'hBFF8, 32'd99, "mtime_99");
    rt_tick();
    check("reload_mtip_100", 64'(mtip), 64'd1);
    rd(16'hBFF8, 32'd100, "mtime_100");

    // 64-bit wrap
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    rd(16'hBFF8, 32'hFFFF_FFFF, "max_lo");
    rd(16'hBFFC, 32'hFFFF_FFFF, "max_hi");
    check("mtip_max", 64'(mtip), 64'd1);
    rt_tick();
    rd(16'hBFF8, 32'h0, "wrap_lo");
    rd(16'hBFFC, 32'h0, "wrap_hi");
    check("mtip_wrap", 64'(mtip), 64'd0);

    // Byte strobes
    wr(16'h4000, 32'hFFFF_FFFF, 4'hF);
    wr(16'h4000, 32'hAABB_CCDD, 4'h2);
    rd(16'h4000, 32'hFFFF_CCFF, "strb_cmp_lo");
    wr(16'h4004, 32'h1122_3344, 4'h9);
    rd(16'h4004, 32'h1100_0044, "strb_cmp_hi");

    // Unmapped decode
    rd(16'h2000, 32'h0, "unmapped_rd");
    wr(16'h2000, 32'hFFFF_FFFF, 4'hF);
    rd(16'h2000, 32'h0, "unmapped_rd2");
    rd(16'h0004, 32'h0, "hart1_msip_absent");
    rd(16'h4000, 32'hFFFF_CCFF, "unmapped_keep_cmp");
    rd(16'h0000, 32'h0, "unmapped_keep_msip");
    rd(16'hBFF8, 32'h0, "unmapped_keep_mtime");

    // Write to mtime high word in a tick cycle drops the tick
    wr(16'hBFF8, 32'h50, 4'hF);
    rt_clk = 1'b1;
    repeat (2) @(negedge clk);
    valid = 1'b1; address = 16'hBFFC; wdata = 32'd5; wstrb = 4'hF;
    push(1'b0, 32'h0, "coll_wr");
    @(negedge clk);
    valid = 1'b0; wstrb = '0;
    collect();
    rt_clk = 1'b0;
    repeat (4) @(negedge clk);
    rd(16'hBFF8, 32'h50, "coll_lo_kept");
    rd(16'hBFFC, 32'd5, "coll_hi");
    rt_tick();
    rd(16'hBFF8, 32'h51, "after_coll_tick");

    // Back-to-back requests
    @(negedge clk);
    valid = 1'b1; address = 16'hBFF8; wstrb = '0;
    push(1'b1, 32'h51, "b2b0");
    @(negedge clk);
    collect();
    address = 16'h4004;
    push(1'b1, 32'h1100_0044, "b2b1");
    @(negedge clk);
    collect();
    address = 16'hBFFC;
    push(1'b1, 32'd5, "b2b2");
    @(negedge clk);
    valid = 1'b0;
    collect();
    @(negedge clk);
    check("ready_idle1", 64'(ready), 64'd0);
    check("rdata_hold", 64'(rdata), 64'd5);

    // Reset together with a request drops the response
    @(negedge clk);
    valid = 1'b1; address = 16'hBFF8; rst = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("rst_drop_ready", 64'(ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_ready", 64'(ready), 64'd0);
    check("rst2_mtip",  64'(mtip),  64'd0);
    check("rst2_rdata", 64'(rdata), 64'd0);
    rd(16'h4000, 32'hFFFF_FFFF, "rst2_cmp_lo");
    rd(16'hBFFC, 32'h0, "rst2_mtime_hi");
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
